// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch unit and the instruction memory.
// The fetch unit is the master: it raises imem_req with imem_addr, and the
// memory answers with imem_ack and imem_rdata in the cycle the data is valid.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage with a one-entry skid buffer and one branch delay slot.
// FETCH keeps a request open at F_pc; an ack either lands in IF/ID or, when
// the hazard unit stalls, in the skid buffer (state FULL, request dropped).
// A taken branch always lets the in-flight/buffered fetch through as the delay
// slot; if that fetch has not completed yet, the target is parked in redir_pc.
module fetch_unit (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         stall,
    input  logic         branch,
    input  logic [31:0]  npc,
    fetch_unit_if.master imem,
    output logic [31:0]  F_pc,
    output logic [31:0]  D_instr,
    output logic [31:0]  D_pc,
    output logic [31:0]  D_pc4,
    output logic         D_valid
);

    typedef enum logic {
        FETCH = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [31:0] RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    state_t      state;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;

    logic        accept;
    logic        handoff;
    logic [31:0] f_pc4;
    logic [31:0] pc_next;

    // A branch only counts when IF/ID holds a real instruction that is moving on.
    assign accept  = D_valid & branch & ~stall;
    assign f_pc4   = F_pc + 32'd4;
    // The delay-slot fetch reaches IF/ID on this edge (from memory or from the skid).
    assign handoff = ~stall & (((state == FETCH) & imem.imem_ack) | (state == FULL));

    // The request is a direct decode of the state register and F_pc.
    assign imem.imem_req  = (state == FETCH);
    assign imem.imem_addr = F_pc;

    // Next-PC priority: fresh branch target, then parked target, then sequential.
    always_comb begin
        // NOTE: default assignment first so every path drives pc_next and no latch is inferred.
        pc_next = f_pc4;
        if (accept) begin
            pc_next = npc;
        end else if (redir_valid) begin
            pc_next = redir_pc;
        end
    end

    // Fetch FSM, IF/ID register, skid buffer and parked redirect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the skid buffer is only two registers, so it is cleared with everything else.
            state       <= FETCH;
            F_pc        <= RESET_PC;
            D_instr     <= '0;
            D_pc        <= '0;
            D_pc4       <= '0;
            D_valid     <= 1'b0;
            redir_valid <= 1'b0;
            redir_pc    <= '0;
            skid_instr  <= '0;
            skid_pc     <= '0;
        end else begin
            // NOTE: non-blocking updates so every register sees the pre-edge values.
            // Branch taken while the delay slot is still outstanding: park the target.
            if (accept && !handoff) begin
                redir_pc    <= npc;
                redir_valid <= 1'b1;
            end

            case (state)
                FETCH: begin
                    if (imem.imem_ack) begin
                        if (!stall) begin
                            D_instr     <= imem.imem_rdata;
                            D_pc        <= F_pc;
                            D_pc4       <= f_pc4;
                            D_valid     <= 1'b1;
                            F_pc        <= pc_next & WORD_MASK;
                            redir_valid <= 1'b0;
                        end else begin
                            skid_instr <= imem.imem_rdata;
                            skid_pc    <= F_pc;
                            state      <= FULL;
                        end
                    end else if (!stall) begin
                        D_valid <= 1'b0;
                    end
                end

                FULL: begin
                    if (!stall) begin
                        D_instr     <= skid_instr;
                        D_pc        <= skid_pc;
                        D_pc4       <= skid_pc + 32'd4;
                        D_valid     <= 1'b1;
                        F_pc        <= pc_next & WORD_MASK;
                        redir_valid <= 1'b0;
                        state       <= FETCH;
                    end
                end

                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a behavioural instruction memory with a
// per-address latency, and two scoreboards -- expected request addresses
// (checked when the memory acks) and expected IF/ID contents (checked when
// an instruction is delivered).
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam logic [31:0] NONE = 32'hFFFF_FFFF;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic        branch;
    logic [31:0] npc;
    logic [31:0] F_pc;
    logic [31:0] D_instr;
    logic [31:0] D_pc;
    logic [31:0] D_pc4;
    logic        D_valid;

    fetch_unit_if imem ();

    fetch_unit dut (
        .clk     (clk),
        .reset_n (reset_n),
        .stall   (stall),
        .branch  (branch),
        .npc     (npc),
        .imem    (imem),
        .F_pc    (F_pc),
        .D_instr (D_instr),
        .D_pc    (D_pc),
        .D_pc4   (D_pc4),
        .D_valid (D_valid)
    );

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_addr[$];
    logic [31:0] exp_pc[$];
    logic [31:0] slow_addr = NONE;
    int          slow_lat  = 0;
    int          wait_cnt  = 0;
    int          lat       = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to 2 ns after the n-th following rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_F_pc"},    F_pc, 32'h0000_3000);
        check({tag, "_D_instr"}, D_instr, 32'h0);
        check({tag, "_D_pc"},    D_pc, 32'h0);
        check({tag, "_D_pc4"},   D_pc4, 32'h0);
        check({tag, "_D_valid"}, {31'b0, D_valid}, 32'h0);
        check({tag, "_req"},     {31'b0, imem.imem_req}, 32'h1);
        check({tag, "_addr"},    imem.imem_addr, 32'h0000_3000);
        check({tag, "_redir"},   {31'b0, dut.redir_valid}, 32'h0);
    endtask

    task automatic start(input string tag, input logic [31:0] s_addr, input int s_lat);
        reset_n   = 1'b0;
        stall     = 1'b0;
        branch    = 1'b0;
        npc       = 32'h0;
        slow_addr = s_addr;
        slow_lat  = s_lat;
        exp_addr.delete();
        exp_pc.delete();
        tick(2);
        check_reset(tag);
        reset_n = 1'b1;
    endtask

    task automatic push_run(input logic [31:0] base, input int n, input bit to_addr, input bit to_pc);
        for (int i = 0; i < n; i++) begin
            if (to_addr) exp_addr.push_back(base + 32'(4 * i));
            if (to_pc)   exp_pc.push_back(base + 32'(4 * i));
        end
    endtask

    task automatic drain(input string tag);
        tick(3);
        check({tag, "_addr_left"}, 32'(exp_addr.size()), 32'h0);
        check({tag, "_pc_left"},   32'(exp_pc.size()), 32'h0);
    endtask

    // Instruction memory: acks an open request after the configured latency.
    initial begin
        imem.imem_ack   = 1'b0;
        imem.imem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (!reset_n || !imem.imem_req) begin
                imem.imem_ack = 1'b0;
                wait_cnt      = 0;
            end else begin
                lat = (imem.imem_addr == slow_addr) ? slow_lat : 0;
                if (wait_cnt >= lat) begin
                    imem.imem_ack   = 1'b1;
                    imem.imem_rdata = instr_of(imem.imem_addr);
                    wait_cnt        = 0;
                    if (exp_addr.size() > 0) check("req_addr", imem.imem_addr, exp_addr.pop_front());
                end else begin
                    imem.imem_ack = 1'b0;
                    wait_cnt++;
                end
            end
        end
    end

    // Delivery monitor: with stall low on an edge, a valid IF/ID is a new instruction.
    initial begin
        logic [31:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (reset_n && !stall && D_valid && exp_pc.size() > 0) begin
                e = exp_pc.pop_front();
                check("deliv_pc",    D_pc, e);
                check("deliv_instr", D_instr, instr_of(e));
                check("deliv_pc4",   D_pc4, e + 32'd4);
            end
        end
    end

    initial begin
        // Zero-wait streaming.
        start("s1_rst", NONE, 0);
        push_run(32'h3000, 3, 1, 1);
        tick(1);
        check("s1_valid", {31'b0, D_valid}, 32'h1);
        check("s1_dpc0", D_pc, 32'h3000);
        check("s1_fpc", F_pc, 32'h3004);
        tick(1);
        check("s1_dpc1", D_pc, 32'h3004);
        tick(1);
        check("s1_dpc2", D_pc, 32'h3008);
        check("s1_addr", imem.imem_addr, 32'h300C);
        drain("s1");

        // Two-cycle wait on 0x3004 gives two bubbles.
        start("s2_rst", 32'h3004, 2);
        push_run(32'h3000, 3, 1, 1);
        tick(1);
        check("s2_dpc0", D_pc, 32'h3000);
        tick(1);
        check("s2_bubble1", {31'b0, D_valid}, 32'h0);
        tick(1);
        check("s2_bubble2", {31'b0, D_valid}, 32'h0);
        check("s2_addr_hold", imem.imem_addr, 32'h3004);
        tick(1);
        check("s2_valid", {31'b0, D_valid}, 32'h1);
        check("s2_dpc1", D_pc, 32'h3004);
        drain("s2");

        // Stall on the cycle 0x3008 returns: skid buffer, request dropped.
        start("s3_rst", NONE, 0);
        push_run(32'h3000, 4, 1, 0);
        push_run(32'h3000, 3, 0, 1);
        tick(2);
        stall = 1'b1;
        tick(1);
        check("s3_full_req", {31'b0, imem.imem_req}, 32'h0);
        check("s3_full_dpc", D_pc, 32'h3004);
        check("s3_full_fpc", F_pc, 32'h3008);
        tick(1);
        check("s3_hold_req", {31'b0, imem.imem_req}, 32'h0);
        check("s3_hold_dpc", D_pc, 32'h3004);
        stall = 1'b0;
        tick(1);
        check("s3_dpc", D_pc, 32'h3008);
        check("s3_req", {31'b0, imem.imem_req}, 32'h1);
        check("s3_next", imem.imem_addr, 32'h300C);
        drain("s3");

        // Branch at 0x3010 with zero-wait delay slot; unaligned target is word-aligned.
        start("s4_rst", NONE, 0);
        push_run(32'h3000, 6, 1, 1);
        push_run(32'h3400, 2, 1, 0);
        exp_pc.push_back(32'h3400);
        tick(5);
        check("s4_br_dpc", D_pc, 32'h3010);
        branch = 1'b1;
        npc    = 32'h3402;
        tick(1);
        branch = 1'b0;
        check("s4_slot", D_pc, 32'h3014);
        check("s4_fpc", F_pc, 32'h3400);
        check("s4_redir", {31'b0, dut.redir_valid}, 32'h0);
        tick(1);
        check("s4_target", D_pc, 32'h3400);
        check("s4_addr", imem.imem_addr, 32'h3404);
        drain("s4");

        // Same branch with the delay slot delayed 3 cycles: target is parked.
        start("s5_rst", 32'h3014, 3);
        push_run(32'h3000, 6, 1, 1);
        push_run(32'h3400, 2, 1, 0);
        exp_pc.push_back(32'h3400);
        tick(5);
        check("s5_br_dpc", D_pc, 32'h3010);
        branch = 1'b1;
        npc    = 32'h3403;
        tick(1);
        branch = 1'b0;
        check("s5_bubble", {31'b0, D_valid}, 32'h0);
        check("s5_redir", {31'b0, dut.redir_valid}, 32'h1);
        check("s5_fpc_wait", F_pc, 32'h3014);
        tick(2);
        check("s5_redir_hold", {31'b0, dut.redir_valid}, 32'h1);
        check("s5_addr_wait", imem.imem_addr, 32'h3014);
        tick(1);
        check("s5_slot", D_pc, 32'h3014);
        check("s5_fpc", F_pc, 32'h3400);
        check("s5_redir_clr", {31'b0, dut.redir_valid}, 32'h0);
        tick(1);
        check("s5_target", D_pc, 32'h3400);
        drain("s5");

        // Reset with a fetch outstanding, then reset while FULL.
        start("s6_rst", 32'h3004, 4);
        exp_pc.push_back(32'h3000);
        tick(2);
        reset_n = 1'b0;
        #1;
        check_reset("s6_async_busy");
        start("s6b_rst", NONE, 0);
        push_run(32'h3000, 3, 1, 0);
        push_run(32'h3000, 2, 0, 1);
        tick(2);
        stall = 1'b1;
        tick(1);
        check("s6_full", {31'b0, imem.imem_req}, 32'h0);
        reset_n = 1'b0;
        #1;
        check_reset("s6_async_full");
        stall = 1'b0;
        exp_addr.delete();
        exp_pc.delete();
        exp_addr.push_back(32'h3000);
        exp_pc.push_back(32'h3000);
        tick(2);
        reset_n = 1'b1;
        check("s6_first_req", imem.imem_addr, 32'h3000);
        tick(1);
        check("s6_first_dpc", D_pc, 32'h3000);
        drain("s6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 SHALL provide the following ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- stall  in  1  hazard unit holds the IF/ID register
- branch  in  1  redirect request for the instruction in IF/ID
- npc  in  32  redirect target
- imem_req  out  1  instruction memory request
- imem_addr  out  32  byte address of the request
- imem_ack  in  1  read data valid this cycle
- imem_rdata  in  32  instruction word
- F_pc  out  32  current fetch PC
- D_instr  out  32  IF/ID instruction
- D_pc  out  32  IF/ID PC
- D_pc4  out  32  IF/ID PC+4, which feeds the next-PC logic
- D_valid  out  1  IF/ID holds a real instruction

Function
REQ-003 SHALL use two FSM states: FETCH and FULL.
- FETCH: imem_req=1, imem_addr=F_pc.
- FULL: imem_req=0.
REQ-004 SHALL define accept = D_valid & branch & !stall; branch SHALL be ignored when D_valid=0 or stall=1.
REQ-005 SHALL select the next PC by priority:
- accept -> npc
- else redir_valid -> redir_pc
- else F_pc+4 (mod 2^32)
REQ-006 SHALL force bits [1:0] of every PC value loaded into F_pc to 00.
REQ-007 In FETCH with imem_ack=1 and stall=0, SHALL on that edge:
- load D_instr=imem_rdata, D_pc=F_pc, D_pc4=F_pc+4 and D_valid=1;
- load F_pc=next PC;
- clear redir_valid;
- remain in FETCH.
REQ-008 In FETCH with imem_ack=1 and stall=1, SHALL capture imem_rdata and F_pc into a one-entry skid buffer, go to FULL, and leave F_pc unchanged.
REQ-009 In FETCH with imem_ack=0 and stall=0, SHALL clear D_valid to insert a bubble.
REQ-010 In FETCH with imem_ack=0 and stall=1, SHALL leave IF/ID unchanged.
REQ-011 In FULL with stall=1, SHALL hold all state and ignore imem_ack.
REQ-012 In FULL with stall=0, SHALL on that edge:
- move the skid buffer into IF/ID with D_valid=1;
- load F_pc=next PC;
- clear redir_valid;
- return to FETCH.
REQ-013 SHALL implement the branch delay slot as follows.
- The fetch in flight, or already buffered, when accept occurs is the delay slot and SHALL always be delivered.
- The redirect SHALL take effect on the PC following that delay slot.
REQ-014 If accept occurs on an edge where the delay-slot fetch is not completing, SHALL latch redir_pc=npc and redir_valid=1.
REQ-015 If accept coincides with the delay-slot hand-off (REQ-007 or REQ-012), SHALL use npc directly and leave redir_valid=0.
REQ-016 A second accept while redir_valid=1 SHALL NOT occur under the pipeline contract; if it does, SHALL overwrite redir_pc with the new npc.
REQ-017 With zero-wait memory (ack in the request cycle) and stall=0, SHALL deliver one instruction per cycle, with D_* updated on the edge after the request.
REQ-018 D_pc4 SHALL always equal D_pc+4 modulo 2^32; PC 0xFFFFFFFC SHALL wrap to 0x00000000.

Reset
REQ-019 On reset_n=0, SHALL immediately set:
- F_pc=0x00003000
- D_instr=0, D_pc=0, D_pc4=0, D_valid=0
- redir_valid=0, redir_pc=0
- skid buffer cleared
- state FETCH
REQ-020 A reset mid-fetch SHALL abandon the outstanding request.
REQ-021 imem_ack during reset, or in the first cycle after release, SHALL NOT be treated as data for the new request unless it occurs in FETCH after release.
REQ-022 After reset_n rises, the first request SHALL be imem_addr=0x00003000 on the first edge.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Reset, zero-wait memory, stall=0 -> imem_addr sequence 0x3000, 0x3004, 0x3008; D_pc follows one cycle later; D_valid=1 from the second edge.
- ack delayed 2 cycles at 0x3004 -> two bubble cycles with D_valid=0; then D_pc=0x3004; no address skipped.
- stall=1 on the cycle ack returns 0x3008 -> state FULL, imem_req=0, IF/ID still holds 0x3004; after stall drops, D_pc=0x3008 and the next request is 0x300C.
- Branch with D_pc=0x3010, npc=0x3400, zero-wait -> delay slot 0x3014 delivered, then the fetch addresses 0x3400.
- Same branch but the delay-slot ack is delayed 3 cycles -> redir_valid=1 while waiting; delivery order 0x3014 then 0x3400; 0x3018 never fetched.
- Assert reset_n=0 while a fetch is outstanding and FSM=FULL -> all outputs return to reset values immediately; the first request after release is 0x00003000.
